lcd_frame_sequencer: RTL and testbench
======================================

LCD_FRAME_SEQUENCER -- requirements
Module: lcd_frame_sequencer

Interface
REQ-001 SHALL have parameter NUM_COLS, default 16, characters per LCD line (2 lines fixed).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000, maximum i_clk cycles o_req may stay high without i_valid.
REQ-003 SHALL have port i_clk  input  1  clock; all logic rises on posedge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_wr_en  input  1  frame-buffer write strobe.
REQ-006 SHALL have port i_wr_addr  input  5  buffer index: 0..15 = line 0, 16..31 = line 1.
REQ-007 SHALL have port i_wr_char  input  8  character code to store.
REQ-008 SHALL have port i_refresh  input  1  one-cycle request to redraw the whole display.
REQ-009 SHALL have port i_valid  input  1  one-cycle completion pulse from the downstream LCD controller.
REQ-010 SHALL have port o_req  output  1  request to the controller is active.
REQ-011 SHALL have port o_func  output  2  controller function: 0 INIT, 1 SETCURSOR, 2 DATA, 3 CMD.
REQ-012 SHALL have port o_data  output  8  controller data/command byte.
REQ-013 SHALL have port o_busy  output  1  a sequence is in progress.
REQ-014 SHALL have port o_init_done  output  1  controller INIT has completed.
REQ-015 SHALL have port o_err  output  1  sticky timeout flag.

Function
REQ-016 SHALL hold a 32x8 frame buffer; i_wr_en writes i_wr_char at i_wr_addr on the same edge, in any state, including while busy.
REQ-017 SHALL implement states IDLE, INIT, W_INIT, CUR, W_CUR, CHR, W_CHR.
REQ-018 Transaction rule: on entering INIT/CUR/CHR, SHALL register o_req=1 with o_func/o_data, then move to the matching W_ state.
REQ-019 In a W_ state, SHALL hold o_req, o_func and o_data stable until i_valid=1 is sampled, then drive o_req=0 on the next edge.
REQ-020 SHALL keep o_req low for at least one cycle between consecutive transactions; i_valid while o_req=0 SHALL be ignored.
REQ-021 After reset, SHALL leave IDLE on the first cycle and issue INIT (o_func=0, o_data=0x00); on its completion SHALL set o_init_done=1 and start a full refresh.
REQ-022 Full refresh order: SETCURSOR o_data=0x00, then DATA for buffer[0..15], then SETCURSOR o_data=0x10, then DATA for buffer[16..31], then IDLE.
REQ-023 SETCURSOR o_data encoding SHALL be line in [7:4] and column in [3:0].
REQ-024 The DATA byte SHALL be read from the buffer in the cycle the CHR state is entered; later writes to that index do not alter the in-flight request.
REQ-025 A 5-bit character index SHALL count 0..31 and wrap to 0 at the end of each refresh.
REQ-026 i_refresh in IDLE SHALL start a refresh on the next edge; if o_init_done=0, SHALL issue INIT first.
REQ-027 i_refresh while busy SHALL set a single pending flag, with multiple pulses merging; on return to IDLE with the flag set, SHALL clear it and start one more refresh.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 A cycle counter SHALL run while o_req=1 and clear on each new transaction.
REQ-030 If the counter reaches TIMEOUT_CYC with no i_valid, SHALL drive o_req=0, set o_err=1, clear the pending flag and go to IDLE.
REQ-031 After an INIT timeout, o_init_done SHALL stay 0.
REQ-032 o_err SHALL be cleared only by reset.
REQ-033 i_valid and the timeout in the same cycle SHALL be treated as success.

Reset
REQ-034 On i_rst_n=0, SHALL immediately set state=IDLE, o_req=0, o_func=0, o_data=0x00, o_busy=0, o_init_done=0, o_err=0, pending=0, index=0, counters=0, and all buffer entries=0x20 (space).
REQ-035 Reset asserted mid-transaction SHALL abort it with no further o_req; after release, behaviour SHALL follow REQ-021.

Verification
REQ-036 Reset release with i_valid returned 5 cycles after each o_req -> INIT, SETCURSOR 0x00, 16 DATA 0x20, SETCURSOR 0x10, 16 DATA 0x20 (35 transactions), then o_init_done=1, o_busy=0.
REQ-037 Write addr 0=0x48, addr 17=0x49, then pulse i_refresh -> first DATA=0x48, 18th DATA (line 1, col 1)=0x49, no INIT reissued.
REQ-038 Three i_refresh pulses during a refresh -> exactly one extra refresh (34 transactions) follows, then IDLE.
REQ-039 With TIMEOUT_CYC=50, never return i_valid -> o_req falls after 50 cycles, o_err=1, o_busy=0; a later i_refresh issues INIT again.
REQ-040 Write addr 5=0x41 in the same cycle CHR for index 5 is entered -> old value sent; the next refresh sends 0x41.
REQ-041 Assert reset while in W_CHR -> all outputs at their reset values at once; buffer is spaces; INIT is issued after release.

Source files
------------

// File: rtl/lcd_frame_sequencer.sv
// Frame-buffer driven refresh sequencer for a 2-line character LCD controller.
// Issues INIT / SETCURSOR / DATA transactions over a req/valid handshake with timeout.
module lcd_frame_sequencer #(
   parameter int NUM_COLS    = 16,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_wr_en,
   input  logic [4:0] i_wr_addr,
   input  logic [7:0] i_wr_char,
   input  logic       i_refresh,
   input  logic       i_valid,
   output logic       o_req,
   output logic [1:0] o_func,
   output logic [7:0] o_data,
   output logic       o_busy,
   output logic       o_init_done,
   output logic       o_err
);

   localparam logic [1:0] F_INIT = 2'd0;
   localparam logic [1:0] F_CUR  = 2'd1;
   localparam logic [1:0] F_DATA = 2'd2;

   localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [4:0]      LAST0    = 5'(NUM_COLS - 1);
   localparam logic [4:0]      LAST1    = 5'(2 * NUM_COLS - 1);

   typedef enum logic [2:0] {
      IDLE, INIT, W_INIT, CUR, W_CUR, CHR, W_CHR
   } state_t;

   state_t           state, state_nxt;
   logic [7:0]       fb [32];
   logic [4:0]       idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             pend, pend_nxt;
   logic             boot, boot_nxt;
   logic             req_nxt, done_nxt, err_nxt;
   logic [1:0]       func_nxt;
   logic [7:0]       data_nxt;
   logic             line;
   logic             in_wait;
   logic             timeout;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) fb[i] <= 8'h20;
      end else if (i_wr_en) begin
         fb[i_wr_addr] <= i_wr_char;
      end
   end

   assign line    = (idx > LAST0);
   assign in_wait = (state == W_INIT) || (state == W_CUR) || (state == W_CHR);
   // i_valid wins over an expiring counter in the same cycle
   assign timeout = in_wait && !i_valid && (cnt == CNT_LAST);
   assign o_busy  = (state != IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_req       <= 1'b0;
         o_func      <= F_INIT;
         o_data      <= 8'h00;
         o_init_done <= 1'b0;
         o_err       <= 1'b0;
         idx         <= 5'd0;
         cnt         <= '0;
         pend        <= 1'b0;
         boot        <= 1'b1;
      end else begin
         o_req       <= req_nxt;
         o_func      <= func_nxt;
         o_data      <= data_nxt;
         o_init_done <= done_nxt;
         o_err       <= err_nxt;
         idx         <= idx_nxt;
         cnt         <= cnt_nxt;
         pend        <= pend_nxt;
         boot        <= boot_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_nxt   = o_req;
      func_nxt  = o_func;
      data_nxt  = o_data;
      done_nxt  = o_init_done;
      err_nxt   = o_err;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      pend_nxt  = pend;
      boot_nxt  = boot;

      if (i_refresh && state != IDLE) pend_nxt = 1'b1;
      if (o_req) cnt_nxt = cnt + 1'b1;

      case (state)
         IDLE: begin
            // boot forces the one automatic INIT after reset release
            if (boot || i_refresh || pend) begin
               boot_nxt  = 1'b0;
               pend_nxt  = 1'b0;
               idx_nxt   = 5'd0;
               state_nxt = o_init_done ? CUR : INIT;
            end
         end
         INIT: begin
            req_nxt   = 1'b1;
            func_nxt  = F_INIT;
            data_nxt  = 8'h00;
            cnt_nxt   = '0;
            state_nxt = W_INIT;
         end
         CUR: begin
            req_nxt   = 1'b1;
            func_nxt  = F_CUR;
            data_nxt  = {3'b000, line, 4'h0};
            cnt_nxt   = '0;
            state_nxt = W_CUR;
         end
         CHR: begin
            req_nxt   = 1'b1;
            func_nxt  = F_DATA;
            data_nxt  = fb[idx];
            cnt_nxt   = '0;
            state_nxt = W_CHR;
         end
         W_INIT: begin
            if (i_valid) begin
               req_nxt   = 1'b0;
               done_nxt  = 1'b1;
               idx_nxt   = 5'd0;
               state_nxt = CUR;
            end
         end
         W_CUR: begin
            if (i_valid) begin
               req_nxt   = 1'b0;
               state_nxt = CHR;
            end
         end
         W_CHR: begin
            if (i_valid) begin
               req_nxt = 1'b0;
               if (idx == LAST1) begin
                  idx_nxt   = 5'd0;
                  state_nxt = IDLE;
               end else if (idx == LAST0) begin
                  idx_nxt   = idx + 5'd1;
                  state_nxt = CUR;
               end else begin
                  idx_nxt   = idx + 5'd1;
                  state_nxt = CHR;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (timeout) begin
         req_nxt   = 1'b0;
         err_nxt   = 1'b1;
         pend_nxt  = 1'b0;
         idx_nxt   = 5'd0;
         state_nxt = IDLE;
      end
   end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed/randomized bench for lcd_frame_sequencer; expected transaction
// streams come from a model frame buffer and the refresh ordering rules.
module tb_lcd_frame_sequencer;

   localparam int TO = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = 5'd0;
   logic [7:0] wr_char = 8'd0;
   logic       refresh = 1'b0;
   logic       valid = 1'b0;
   logic       req, busy, init_done, err;
   logic [1:0] func;
   logic [7:0] data;

   int         n_assert = 0;
   int         n_fail = 0;
   logic [7:0] mbuf [32];
   int         inj_idx = -1;
   logic [7:0] inj_char = 8'h00;
   int         ref_pulses = 0;
   int         cur_lat = 0;

   lcd_frame_sequencer #(.NUM_COLS(16), .TIMEOUT_CYC(TO)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_wr_en     (wr_en),
      .i_wr_addr   (wr_addr),
      .i_wr_char   (wr_char),
      .i_refresh   (refresh),
      .i_valid     (valid),
      .o_req       (req),
      .o_func      (func),
      .o_data      (data),
      .o_busy      (busy),
      .o_init_done (init_done),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [4:0] a, input logic [7:0] c);
      wr_en = 1'b1; wr_addr = a; wr_char = c;
      @(negedge clk);
      wr_en = 1'b0;
      mbuf[a] = c;
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   // Answer one transaction: check it, hold for lat cycles, return i_valid.
   task automatic serve(input logic [1:0] ef, input logic [7:0] ed, input int lat_in, input bit inject);
      int n;
      int lat;
      n = 0;
      lat = (lat_in > 0) ? lat_in : int'($urandom_range(1, 6));
      while (req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("req_rise", req, 1);
      chk("func", func, ef);
      chk("data", data, ed);
      chk("busy", busy, 1);
      for (int k = 1; k < lat; k++) begin
         if (k == 1 && ref_pulses > 0) begin
            refresh = 1'b1;
            ref_pulses--;
         end
         @(negedge clk);
         refresh = 1'b0;
         chk("hold", {req, func, data}, {1'b1, ef, ed});
      end
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("req_fall", req, 0);
      if (inject) write(5'(inj_idx), inj_char);
   endtask

   task automatic expect_refresh(input bit with_init);
      logic [7:0] snap [32];
      snap = mbuf;
      if (with_init) begin
         serve(2'd0, 8'h00, 0, 1'b0);
         chk("init_done_set", init_done, 1);
      end
      for (int ln = 0; ln < 2; ln++) begin
         serve(2'd1, (ln == 1) ? 8'h10 : 8'h00, (ln == 0) ? cur_lat : 0, 1'b0);
         for (int col = 0; col < 16; col++) begin
            serve(2'd2, snap[ln*16 + col], 0, (ln*16 + col) == inj_idx - 1);
         end
      end
      cur_lat = 0;
   endtask

   initial begin
      int n;
      int hi;
      for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;

      repeat (3) @(negedge clk);
      chk("rst_req", req, 0);
      chk("rst_func", func, 0);
      chk("rst_data", data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_err", err, 0);

      // boot: INIT then full refresh of spaces
      rst_n = 1'b1;
      expect_refresh(1'b1);
      chk("boot_busy", busy, 0);
      chk("boot_init_done", init_done, 1);
      chk("boot_err", err, 0);

      // i_valid with no request outstanding is ignored
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_valid_req", req, 0);
      chk("stray_valid_busy", busy, 0);

      // targeted and random writes; first cursor answered on the timeout cycle
      write(5'd0, 8'h48);
      write(5'd17, 8'h49);
      for (int i = 0; i < 6; i++) begin
         write(5'($urandom_range(1, 15)), 8'($urandom_range(0, 255)));
         write(5'($urandom_range(18, 31)), 8'($urandom_range(0, 255)));
      end
      cur_lat = TO;
      pulse_refresh();
      expect_refresh(1'b0);
      chk("valid_on_timeout_err", err, 0);
      chk("refresh_busy", busy, 0);

      // three refresh pulses while busy merge into one extra refresh
      pulse_refresh();
      ref_pulses = 3;
      expect_refresh(1'b0);
      expect_refresh(1'b0);
      repeat (10) @(negedge clk);
      chk("merge_idle_req", req, 0);
      chk("merge_idle_busy", busy, 0);

      // write to index 5 in the cycle its CHR is entered
      write(5'd5, 8'h30);
      inj_idx = 5;
      inj_char = 8'h41;
      pulse_refresh();
      expect_refresh(1'b0);
      inj_idx = -1;
      pulse_refresh();
      expect_refresh(1'b0);

      // reset asserted while a DATA request is outstanding
      pulse_refresh();
      serve(2'd1, 8'h00, 0, 1'b0);
      serve(2'd2, mbuf[0], 0, 1'b0);
      serve(2'd2, mbuf[1], 0, 1'b0);
      n = 0;
      while (req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("wchr_req", req, 1);
      chk("wchr_func", func, 2);
      rst_n = 1'b0;
      #1;
      chk("arst_req", req, 0);
      chk("arst_func", func, 0);
      chk("arst_data", data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_init_done", init_done, 0);
      chk("arst_err", err, 0);
      repeat (4) @(negedge clk);
      chk("arst_hold_req", req, 0);
      for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
      rst_n = 1'b1;
      expect_refresh(1'b1);

      // INIT never answered: timeout
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (req !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("to_req_rise", req, 1);
      chk("to_func", func, 0);
      hi = 1;
      while (req === 1'b1 && hi < 200) begin
         @(negedge clk);
         if (req === 1'b1) hi++;
      end
      chk("timeout_len", hi, TO);
      chk("to_err", err, 1);
      chk("to_busy", busy, 0);
      chk("to_init_done", init_done, 0);
      repeat (5) @(negedge clk);
      chk("to_no_retry", req, 0);
      pulse_refresh();
      expect_refresh(1'b1);
      chk("err_sticky", err, 1);
      chk("final_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
